// File: rtl/uart_pkg.sv
// Shared types and helpers for the multi-byte UART frame transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StGap
    } state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Clock cycles per bit, truncated.
    function automatic int unsigned cpb(input int unsigned freq, input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter: one-cycle tick at the end of every CPB-cycle bit period.
module uart_baud_tick #(
    parameter int unsigned CPB = 10
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic clear_in,
    output logic tick_out
);

    localparam int unsigned CW = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);

    logic [CW-1:0] cnt_q;

    // The tick must not depend on clear_in: the caller derives clear_in from the tick.
    assign tick_out = (cnt_q == LAST);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else if (clear_in || tick_out) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Multi-byte UART frame transmitter: accepts up to MAX_BYTES bytes per handshake and sends them
// as back-to-back characters with optional parity, 1/2 stop bits and inter-character gap.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int unsigned MAX_BYTES        = 4,
    parameter int unsigned DATA_BITS        = 8,
    parameter int unsigned BAUD_RATE        = 9600,
    parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000,
    parameter int unsigned PARITY           = 0,
    parameter int unsigned STOP_BITS        = 1,
    parameter int unsigned GAP_BITS         = 0,
    parameter int unsigned MSB_FIRST_BYTES  = 0
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic                             valid_in,
    input  logic [8*MAX_BYTES-1:0]           data_in,
    input  logic [$clog2(MAX_BYTES+1)-1:0]   len_in,
    output logic                             ready_out,
    output logic                             busy_out,
    output logic                             done_out,
    output logic                             tx_wire_out
);

    localparam int unsigned CPB     = cpb(INPUT_CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned LW      = $clog2(MAX_BYTES + 1);
    localparam int unsigned IW      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int unsigned CNT_MAX = (GAP_BITS > DATA_BITS) ? GAP_BITS : DATA_BITS;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_BYTES);

    if (CPB < 2) begin : g_bad_cpb
        $error("uart_frame_tx: INPUT_CLOCK_FREQ/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_frame_tx: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_frame_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_frame_tx: PARITY must be 0, 1 or 2");
    end
    if (MAX_BYTES < 1) begin : g_bad_max_bytes
        $error("uart_frame_tx: MAX_BYTES must be at least 1");
    end

    function automatic logic parity_of(input logic [DATA_BITS-1:0] b);
        return (PARITY == PAR_ODD) ? ~^b : ^b;
    endfunction

    state_t                 state_q;
    logic [8*MAX_BYTES-1:0] frame_q;
    logic [LW-1:0]          rem_q;
    logic [IW-1:0]          idx_q;
    logic [CW-1:0]          bit_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;
    logic                   tx_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   tick;
    logic                   bit_end;
    logic                   state_end;
    logic                   baud_clear;
    logic [LW-1:0]          len_clamped;
    logic [IW-1:0]          first_idx;
    logic [IW-1:0]          next_idx;
    logic [DATA_BITS-1:0]   first_byte;
    logic [DATA_BITS-1:0]   next_byte;

    assign len_clamped = (len_in > LEN_MAX) ? LEN_MAX : len_in;
    assign first_idx   = (MSB_FIRST_BYTES != 0) ? IW'(len_clamped - 1'b1) : '0;
    assign next_idx    = (MSB_FIRST_BYTES != 0) ? idx_q - 1'b1 : idx_q + 1'b1;
    // The first byte comes straight from data_in since frame_q loads on the same edge.
    assign first_byte  = data_in[8*first_idx +: DATA_BITS];
    assign next_byte   = frame_q[8*next_idx +: DATA_BITS];

    always_comb begin
        bit_end = 1'b0;
        case (state_q)
            StStart, StParity: bit_end = 1'b1;
            StData:            bit_end = (bit_cnt_q == DATA_LAST);
            StStop:            bit_end = (bit_cnt_q == STOP_LAST);
            StGap:             bit_end = (bit_cnt_q == GAP_LAST);
            default:           bit_end = 1'b0;
        endcase
    end

    assign state_end  = tick & bit_end;
    // Holding the counter clear in idle restarts bit timing exactly at the accept edge.
    assign baud_clear = (state_q == StIdle) | state_end;

    uart_baud_tick #(
        .CPB (CPB)
    ) u_baud_tick (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clear_in (baud_clear),
        .tick_out (tick)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= StIdle;
            frame_q   <= '0;
            rem_q     <= '0;
            idx_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (valid_in) begin
                        frame_q <= data_in;
                        if (len_clamped == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            rem_q   <= len_clamped;
                            idx_q   <= first_idx;
                            shift_q <= first_byte;
                            par_q   <= parity_of(first_byte);
                            tx_q    <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= StStart;
                        end
                    end
                end
                StStart: begin
                    if (tick) begin
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= '0;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (tick) begin
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_q <= '0;
                            if (PARITY != PAR_NONE) begin
                                tx_q    <= par_q;
                                state_q <= StParity;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= StStop;
                            end
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                StParity: begin
                    if (tick) begin
                        tx_q      <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= StStop;
                    end
                end
                StStop: begin
                    if (tick) begin
                        if (bit_cnt_q != STOP_LAST) begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end else if (rem_q == LW'(1)) begin
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            rem_q     <= rem_q - 1'b1;
                            idx_q     <= next_idx;
                            shift_q   <= next_byte;
                            par_q     <= parity_of(next_byte);
                            bit_cnt_q <= '0;
                            if (GAP_BITS > 0) begin
                                state_q <= StGap;
                            end else begin
                                tx_q    <= 1'b0;
                                state_q <= StStart;
                            end
                        end
                    end
                end
                StGap: begin
                    if (tick) begin
                        if (bit_cnt_q == GAP_LAST) begin
                            tx_q    <= 1'b0;
                            state_q <= StStart;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready_out   = (state_q == StIdle);
    assign busy_out    = busy_q;
    assign done_out    = done_q;
    assign tx_wire_out = tx_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: five configurations, bit-level scoreboard per frame.
module tb_uart_frame_tx;

    localparam int NI  = 5;
    localparam int CPB = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NI-1:0] valid;
    logic [31:0]   data;
    logic [2:0]    len;
    logic [NI-1:0] ready;
    logic [NI-1:0] busy;
    logic [NI-1:0] done;
    logic [NI-1:0] tx;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    // Instance 0 defaults, 1 MSB-first, 2 even parity, 3 odd parity, 4 two stop bits + gap.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_frame_tx #(
            .MAX_BYTES        (4),
            .DATA_BITS        (8),
            .BAUD_RATE        (100),
            .INPUT_CLOCK_FREQ (1000),
            .PARITY           ((g == 2) ? 2 : ((g == 3) ? 1 : 0)),
            .STOP_BITS        ((g == 4) ? 2 : 1),
            .GAP_BITS         ((g == 4) ? 2 : 0),
            .MSB_FIRST_BYTES  ((g == 1) ? 1 : 0)
        ) u_dut (
            .clk_in      (clk),
            .rst_n_in    (rst_n),
            .valid_in    (valid[g]),
            .data_in     (data),
            .len_in      (len),
            .ready_out   (ready[g]),
            .busy_out    (busy[g]),
            .done_out    (done[g]),
            .tx_wire_out (tx[g])
        );
    end

    function automatic int cfg_msb(input int i);
        return (i == 1) ? 1 : 0;
    endfunction
    function automatic int cfg_par(input int i);
        return (i == 2) ? 2 : ((i == 3) ? 1 : 0);
    endfunction
    function automatic int cfg_stop(input int i);
        return (i == 4) ? 2 : 1;
    endfunction
    function automatic int cfg_gap(input int i);
        return (i == 4) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sends one frame on instance inst and checks every bit mid-period plus done/busy timing.
    task automatic run_frame(input int inst, input logic [31:0] d, input int l,
                             input string tag, input bit hold);
        int       lv;
        int       total;
        int       done_at;
        int       done_cnt;
        int       busy_cnt;
        int       e;
        int       idx;
        logic [7:0] b;
        exp_q.delete();
        lv = (l > 4) ? 4 : l;
        for (int k = 0; k < lv; k++) begin
            idx = (cfg_msb(inst) != 0) ? lv - 1 - k : k;
            b = d[8*idx +: 8];
            exp_q.push_back(0);
            for (int j = 0; j < 8; j++) exp_q.push_back(int'(b[j]));
            if (cfg_par(inst) == 2) exp_q.push_back(int'(^b));
            else if (cfg_par(inst) == 1) exp_q.push_back(int'(~^b));
            for (int j = 0; j < cfg_stop(inst); j++) exp_q.push_back(1);
            if (k < lv - 1) for (int j = 0; j < cfg_gap(inst); j++) exp_q.push_back(1);
        end
        total = exp_q.size() * CPB;

        @(negedge clk);
        data = d;
        len = 3'(l);
        valid[inst] = 1'b1;
        check({tag, "_ready"}, int'(ready[inst]), 1);
        @(negedge clk);
        if (!hold) begin
            valid[inst] = 1'b0;
            data = $urandom;
            len = 3'($urandom_range(0, 7));
        end

        done_at = -1;
        done_cnt = 0;
        busy_cnt = 0;
        for (int n = 1; n <= total + 3; n++) begin
            if (n > 1) @(negedge clk);
            if (busy[inst] && n <= total + 1) busy_cnt++;
            if (done[inst]) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (n == 2 && total > 0) check({tag, "_ready_busy"}, int'(ready[inst]), 0);
            if (total == 0) check($sformatf("%s_idle_line%0d", tag, n), int'(tx[inst]), 1);
            if (n <= total && (n - 1) % CPB == CPB / 2) begin
                e = exp_q.pop_front();
                check($sformatf("%s_bit%0d", tag, (n - 1) / CPB), int'(tx[inst]), e);
            end
            if (hold && n == total + 2) begin
                check({tag, "_restart_tx"}, int'(tx[inst]), 0);
                check({tag, "_restart_busy"}, int'(busy[inst]), 1);
            end
        end
        check({tag, "_done_at"}, done_at, total + 1);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_cycles"}, busy_cnt, total);
        check({tag, "_bits_left"}, exp_q.size(), 0);
        if (!hold) check({tag, "_line_idle"}, int'(tx[inst]), 1);
        valid[inst] = 1'b0;
    endtask

    initial begin
        int dn;
        rst_n = 1'b1;
        valid = '0;
        data  = '0;
        len   = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx", int'(tx[0]), 1);
        check("rst_busy", int'(busy[0]), 0);
        check("rst_done", int'(done[0]), 0);
        check("rst_ready", int'(ready[0]), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_frame(0, 32'h44332211, 4, "t1_lsb", 1'b0);
        run_frame(1, 32'h0000BBAA, 2, "t2_msb", 1'b0);
        run_frame(2, 32'h00000007, 1, "t3_even", 1'b0);
        run_frame(3, 32'h00000007, 1, "t3_odd", 1'b0);
        run_frame(4, 32'h00C35A96, 3, "t4_gap", 1'b0);

        // Reset asserted between clock edges during a data bit of byte 1.
        @(negedge clk);
        data = 32'h44332211;
        len = 3'd4;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (13 * CPB + 2) @(negedge clk);
        check("t5_busy_before", int'(busy[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_tx_async", int'(tx[0]), 1);
        check("t5_busy_async", int'(busy[0]), 0);
        check("t5_ready_async", int'(ready[0]), 1);
        dn = 0;
        repeat (3) begin
            @(posedge clk);
            #1 if (done[0]) dn++;
        end
        #3 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done[0]) dn++;
            if (!tx[0]) dn++;
        end
        check("t5_quiet_after_reset", dn, 0);
        run_frame(0, 32'hDEADBEEF, 4, "t5_after", 1'b0);

        run_frame(0, 32'h12345678, 0, "t6_len0", 1'b0);
        run_frame(0, 32'hA5C3E781, 7, "t6_len7", 1'b0);
        run_frame(0, 32'h0000005A, 1, "t6_hold", 1'b1);
        pulse_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
